// File: rtl/btn_pkg.sv
// Shared defaults and helpers for the multi-channel button filter.
package btn_pkg;

  localparam int CNTR_WIDTH_DEF = 4;
  localparam int LONG_WIDTH_DEF = 8;

  // True when the low w bits of v are all ones and the rest are zero.
  function automatic logic all_ones(input logic [31:0] v, input int unsigned w);
    return v == 32'((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/btn_filter_ch.sv
// One button channel: 2-flop synchroniser, CE-paced debounce, stable level,
// press/release pulses and a single long-press pulse per accepted press.
module btn_filter_ch
  import btn_pkg::*;
#(
  parameter int   CNTR_WIDTH = CNTR_WIDTH_DEF,
  parameter int   LONG_WIDTH = LONG_WIDTH_DEF,
  parameter logic INV        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold,
  output logic press_next
);

  logic                  d, s1, s2;
  logic [CNTR_WIDTH-1:0] fc;
  logic [LONG_WIDTH-1:0] hc, hc_inc;
  logic                  fc_full, hc_full, accept, hold_set;

  assign fc_full    = all_ones(32'(fc), CNTR_WIDTH);
  assign hc_full    = all_ones(32'(hc), LONG_WIDTH);
  assign hc_inc     = hc + 1'b1;
  assign accept     = (s1 != s2) && ce && fc_full;
  assign press_next = accept && s1;
  // An accept edge clears HC, so a release acceptance can never fire a long pulse.
  assign hold_set   = s2 && ce && !accept && !hc_full && all_ones(32'(hc_inc), LONG_WIDTH);
  assign level      = s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      d     <= 1'b0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      fc    <= '0;
      hc    <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
      hold  <= 1'b0;
    end else begin
      d     <= btn ^ INV;
      s1    <= d;
      press <= accept && s1;
      rel   <= accept && !s1;
      hold  <= hold_set;

      if (s1 == s2) begin
        fc <= '0;
      end else if (ce) begin
        if (fc_full) begin
          s2 <= s1;
          fc <= '0;
        end else begin
          fc <= fc + 1'b1;
        end
      end

      if (accept || !s2)
        hc <= '0;
      else if (ce && !hc_full)
        hc <= hc_inc;
    end
  end

endmodule

// File: rtl/btn_filter_multi.sv
// N_CH independent debounced button channels sharing one CE tick, plus a
// registered any-press flag aligned with the per-channel press pulses.
module btn_filter_multi
  import btn_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter int              CNTR_WIDTH = CNTR_WIDTH_DEF,
  parameter int              LONG_WIDTH = LONG_WIDTH_DEF,
  parameter logic [N_CH-1:0] INV_MASK   = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic [N_CH-1:0] BTN_IN,
  output logic [N_CH-1:0] BTN_OUT,
  output logic [N_CH-1:0] BTN_PRESS,
  output logic [N_CH-1:0] BTN_RELEASE,
  output logic [N_CH-1:0] BTN_LONG,
  output logic            BTN_ANY
);

  logic [N_CH-1:0] press_next;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_filter_ch #(
      .CNTR_WIDTH(CNTR_WIDTH),
      .LONG_WIDTH(LONG_WIDTH),
      .INV       (INV_MASK[i])
    ) u_ch (
      .clk       (CLK),
      .rst       (RST),
      .ce        (CE),
      .btn       (BTN_IN[i]),
      .level     (BTN_OUT[i]),
      .press     (BTN_PRESS[i]),
      .rel       (BTN_RELEASE[i]),
      .hold      (BTN_LONG[i]),
      .press_next(press_next[i])
    );
  end

  // Registered from the same accept terms so it lines up with BTN_PRESS.
  always_ff @(posedge CLK) begin
    if (RST) BTN_ANY <= 1'b0;
    else     BTN_ANY <= |press_next;
  end

endmodule
